// File: rtl/wide_add_seq.sv
// Byte-serial WORDS x W-bit adder sequencer driving one shared external W-bit adder, LSB slice first.
// Optional subtract mode: define WIDE_ADD_SEQ_SUB_EN to add the op_sub port (a - b, cout=1 means no borrow).
module wide_add_seq #(
   parameter int W     = 8,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [W*WORDS-1:0] a_in,
   input  logic [W*WORDS-1:0] b_in,
   input  logic               cin,
`ifdef WIDE_ADD_SEQ_SUB_EN
   input  logic               op_sub,
`endif
   output logic [W-1:0]       add_a,
   output logic [W-1:0]       add_b,
   output logic               add_cin,
   input  logic [W-1:0]       add_sum,
   input  logic               add_cout,
   output logic               busy,
   output logic               done,
   output logic [W*WORDS-1:0] sum_out,
   output logic               cout
);

   localparam int N  = W * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
   localparam logic [IW-1:0] ONE_IDX  = IW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r;
   logic [IW-1:0] idx_r;
   logic          carry_r;
   logic          sub_r;
   logic [N-1:0]  a_r;
   logic [N-1:0]  b_r;
   logic [N-1:0]  acc_r;
   logic [N-1:0]  sum_r;
   logic          cout_r;
   logic          busy_r;
   logic          done_r;

   logic          sub_in_s;
   logic          carry_init_s;
   logic [W-1:0]  a_slice_s;
   logic [W-1:0]  b_slice_s;
   logic [N-1:0]  acc_next_s;

`ifdef WIDE_ADD_SEQ_SUB_EN
   assign sub_in_s = op_sub;
`else
   assign sub_in_s = 1'b0;
`endif

   // Subtraction is a + ~b + 1, so the incoming carry is forced high.
   assign carry_init_s = sub_in_s ? 1'b1 : cin;

   // Adder operands come from latched registers only, and are zero outside RUN.
   always_comb begin
      a_slice_s = a_r[idx_r*W +: W];
      b_slice_s = b_r[idx_r*W +: W];
      if (state_r == RUN) begin
         add_a   = a_slice_s;
         add_b   = sub_r ? ~b_slice_s : b_slice_s;
         add_cin = carry_r;
      end else begin
         add_a   = {W{1'b0}};
         add_b   = {W{1'b0}};
         add_cin = 1'b0;
      end
   end

   // Accumulator with the current slice merged in, so the final byte lands in the same edge.
   always_comb begin
      acc_next_s = acc_r;
      acc_next_s[idx_r*W +: W] = add_sum;
   end

   // Sequencer FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         idx_r   <= {IW{1'b0}};
         carry_r <= 1'b0;
         sub_r   <= 1'b0;
         a_r     <= {N{1'b0}};
         b_r     <= {N{1'b0}};
         acc_r   <= {N{1'b0}};
         sum_r   <= {N{1'b0}};
         cout_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  a_r     <= a_in;
                  b_r     <= b_in;
                  sub_r   <= sub_in_s;
                  carry_r <= carry_init_s;
                  idx_r   <= {IW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               acc_r   <= acc_next_s;
               carry_r <= add_cout;
               if (idx_r == LAST_IDX) begin
                  idx_r   <= {IW{1'b0}};
                  sum_r   <= acc_next_s;
                  cout_r  <= add_cout;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= DONE;
               end else begin
                  idx_r <= idx_r + ONE_IDX;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign sum_out = sum_r;
   assign cout    = cout_r;

endmodule
